// File: rtl/poly_pkg.sv
// poly_pkg: shared widths, reduction depth and FSM encoding for the polynomial evaluator.
package poly_pkg;
   localparam int WID_D   = 32;
   localparam int CNT_W   = 5;
   localparam int ORD_NUM = 30;
   typedef enum logic [1:0] {IDLE, PREP, RUN} state_e;
endpackage

// File: rtl/pair_mac_if.sv
// pair_mac_if: pairing-queue pop port and result-return port.
interface pair_mac_if;
   logic [poly_pkg::WID_D-1:0] a_left, a_right, data_out;
   logic [poly_pkg::CNT_W-1:0] order_cnt_i, order_cnt_out;
   logic                       dt_vld_i, mux2que_rdy, dt_vld_out;
   modport master (
      output a_left, a_right, order_cnt_i, dt_vld_i,
      input  mux2que_rdy, data_out, order_cnt_out, dt_vld_out
   );
   modport slave (
      input  a_left, a_right, order_cnt_i, dt_vld_i,
      output mux2que_rdy, data_out, order_cnt_out, dt_vld_out
   );
endinterface

// File: rtl/mul_trunc.sv
// mul_trunc: W x W multiplier keeping only the low W bits of the product.
module mul_trunc #(parameter int W = 32) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] p_o
);
   assign p_o = a_i * b_i;
endmodule

// File: rtl/pair_mac.sv
// pair_mac: pops {a_left, a_right, cnt} pairs and returns a_left + a_right * x^(2^cnt) with cnt + 1.
// Builds the squared-power table of x first; one multiplier serves both table build and pair products.
module pair_mac import poly_pkg::*; (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WID_D-1:0] x_in,
   pair_mac_if.slave        q,
   output logic             x_rdy,
   output logic             cnt_err
);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] prep_cnt_q, prep_cnt_d, pidx, idx;
   logic             cnt_err_q, cnt_err_d;
   logic [WID_D-1:0] pow_q [ORD_NUM];
   logic [WID_D-1:0] mul_a, mul_b, mul_p;
   logic             start_acc, pop, in_rng;
   logic             s1_vld_q, s2_vld_q, vld_q;
   logic [WID_D-1:0] s1_al_q, s1_prod_q, s2_al_q, s2_prod_q, data_q;
   logic [CNT_W-1:0] s1_cnt_q, s2_cnt_q, ocnt_q;

   mul_trunc #(.W(WID_D)) u_mul (.a_i(mul_a), .b_i(mul_b), .p_o(mul_p));

   always_comb begin
      start_acc  = start && state_q != PREP;
      pop        = q.dt_vld_i && state_q == RUN && !start;
      in_rng     = q.order_cnt_i < CNT_W'(ORD_NUM);
      idx        = in_rng ? q.order_cnt_i : '0;
      pidx       = prep_cnt_q - CNT_W'(1);
      mul_a      = state_q == PREP ? pow_q[pidx] : q.a_right;
      mul_b      = state_q == PREP ? pow_q[pidx] : pow_q[idx];
      state_d    = start_acc ? PREP :
                   (state_q == PREP && prep_cnt_q == CNT_W'(ORD_NUM - 1)) ? RUN : state_q;
      prep_cnt_d = start_acc ? CNT_W'(1) : state_q == PREP ? prep_cnt_q + CNT_W'(1) : prep_cnt_q;
      cnt_err_d  = start_acc ? 1'b0 : cnt_err_q | (pop && !in_rng);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         prep_cnt_q <= '0;
         cnt_err_q  <= 1'b0;
         for (int i = 0; i < ORD_NUM; i++) pow_q[i] <= '0;
         s1_vld_q   <= 1'b0;
         s2_vld_q   <= 1'b0;
         vld_q      <= 1'b0;
         s1_al_q    <= '0;
         s1_prod_q  <= '0;
         s1_cnt_q   <= '0;
         s2_al_q    <= '0;
         s2_prod_q  <= '0;
         s2_cnt_q   <= '0;
         data_q     <= '0;
         ocnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         prep_cnt_q <= prep_cnt_d;
         cnt_err_q  <= cnt_err_d;
         if (start_acc) pow_q[0] <= x_in;
         else if (state_q == PREP) pow_q[prep_cnt_q] <= mul_p;
         // out-of-range pairs are consumed but never enter the pipeline
         s1_vld_q <= pop && in_rng;
         if (pop) begin
            s1_al_q   <= q.a_left;
            s1_prod_q <= mul_p;
            s1_cnt_q  <= q.order_cnt_i;
         end
         s2_vld_q  <= s1_vld_q;
         s2_al_q   <= s1_al_q;
         s2_prod_q <= s1_prod_q;
         s2_cnt_q  <= s1_cnt_q;
         vld_q     <= s2_vld_q;
         if (s2_vld_q) begin
            data_q <= s2_al_q + s2_prod_q;
            ocnt_q <= s2_cnt_q + CNT_W'(1);
         end
      end
   end

   assign q.mux2que_rdy   = state_q == RUN;
   assign q.data_out      = data_q;
   assign q.order_cnt_out = ocnt_q;
   assign q.dt_vld_out    = vld_q;
   assign x_rdy           = state_q == RUN;
   assign cnt_err         = cnt_err_q;
endmodule

// File: tb/tb_pair_mac.sv
// tb_pair_mac: directed vectors with hand-computed results for pair_mac.
module tb_pair_mac;
   import poly_pkg::*;
   logic             clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [WID_D-1:0] x_in = '0;
   logic             x_rdy, cnt_err;
   int               n_cmp = 0, n_bad = 0;

   pair_mac_if q_if ();
   pair_mac dut (.clk(clk), .rst(rst), .start(start), .x_in(x_in), .q(q_if.slave),
                 .x_rdy(x_rdy), .cnt_err(cnt_err));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] al, input logic [31:0] ar, input logic [4:0] c, input logic v);
      q_if.a_left      = al;
      q_if.a_right     = ar;
      q_if.order_cnt_i = c;
      q_if.dt_vld_i    = v;
   endtask

   task automatic wait_ready(input string tag, input int n0);
      int n = n0;
      while (!x_rdy && n < 100) begin
         tick();
         n++;
      end
      chk(tag, n, 29);
      chk({tag, "_rdy"}, q_if.mux2que_rdy, 1);
   endtask

   task automatic build(input string tag, input logic [31:0] x);
      start = 1'b1;
      x_in  = x;
      tick();
      start = 1'b0;
      chk({tag, "_prep_rdy"}, q_if.mux2que_rdy, 0);
      wait_ready(tag, 0);
   endtask

   task automatic send(input string tag, input logic [31:0] al, input logic [31:0] ar,
                       input logic [4:0] c, input logic [31:0] exp_d, input logic [4:0] exp_c);
      chk({tag, "_rdy"}, q_if.mux2que_rdy, 1);
      drive(al, ar, c, 1'b1);
      tick();
      q_if.dt_vld_i = 1'b0;
      tick();
      chk({tag, "_early"}, q_if.dt_vld_out, 0);
      tick();
      chk({tag, "_vld"}, q_if.dt_vld_out, 1);
      chk({tag, "_d"}, q_if.data_out, exp_d);
      chk({tag, "_c"}, q_if.order_cnt_out, exp_c);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rdy"}, q_if.mux2que_rdy, 0);
      chk({tag, "_d"}, q_if.data_out, 0);
      chk({tag, "_c"}, q_if.order_cnt_out, 0);
      chk({tag, "_vld"}, q_if.dt_vld_out, 0);
      chk({tag, "_xrdy"}, x_rdy, 0);
      chk({tag, "_err"}, cnt_err, 0);
   endtask

   logic [31:0] pw2 [6] = '{32'd2, 32'd4, 32'd16, 32'd256, 32'd65536, 32'd0};
   logic [31:0] b_al [8] = '{1, 11, 21, 31, 41, 51, 61, 71};
   logic [31:0] b_ar [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
   logic [4:0]  b_c  [8] = '{0, 1, 2, 3, 4, 0, 1, 29};
   logic [31:0] b_d  [8] = '{3, 19, 69, 1055, 327721, 63, 89, 71};
   logic [4:0]  b_oc [8] = '{1, 2, 3, 4, 5, 1, 2, 30};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal;
   end

   initial begin
      drive(0, 0, 0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      chk_zero("reset");

      build("build2", 32'd2);
      for (int k = 0; k < 6; k++)
         send($sformatf("pow%0d", k), 0, 1, 5'(k), pw2[k], 5'(k + 1));
      send("p3_5", 3, 5, 0, 13, 1);
      send("p1_1", 1, 1, 2, 17, 3);
      send("p7_9", 7, 9, 5, 7, 6);

      for (int c = 0; c < 10; c++) begin
         if (c < 8) drive(b_al[c], b_ar[c], b_c[c], 1'b1);
         else q_if.dt_vld_i = 1'b0;
         tick();
         if (c >= 2) begin
            chk($sformatf("b2b%0d_vld", c - 2), q_if.dt_vld_out, 1);
            chk($sformatf("b2b%0d_d", c - 2), q_if.data_out, b_d[c - 2]);
            chk($sformatf("b2b%0d_c", c - 2), q_if.order_cnt_out, b_oc[c - 2]);
         end
      end
      tick();
      chk("b2b_end_vld", q_if.dt_vld_out, 0);

      drive(1, 1, 31, 1'b1);
      tick();
      q_if.dt_vld_i = 1'b0;
      chk("oor_err", cnt_err, 1);
      chk("oor_rdy", q_if.mux2que_rdy, 1);
      tick();
      tick();
      chk("oor_drop", q_if.dt_vld_out, 0);
      repeat (3) tick();
      chk("oor_sticky", cnt_err, 1);

      drive(3, 5, 0, 1'b1);
      tick();
      drive(1, 1, 2, 1'b1);
      tick();
      drive(1, 1, 0, 1'b1);
      start = 1'b1;
      x_in  = 32'hFFFF_FFFF;
      tick();
      start = 1'b0;
      chk("inf0_vld", q_if.dt_vld_out, 1);
      chk("inf0_d", q_if.data_out, 13);
      chk("inf_rdy_low", q_if.mux2que_rdy, 0);
      chk("inf_err_clr", cnt_err, 0);
      tick();
      chk("inf1_vld", q_if.dt_vld_out, 1);
      chk("inf1_d", q_if.data_out, 17);
      chk("inf1_c", q_if.order_cnt_out, 3);
      tick();
      chk("inf_nopop", q_if.dt_vld_out, 0);
      wait_ready("inf_prep", 2);
      tick();
      q_if.dt_vld_i = 1'b0;
      tick();
      tick();
      chk("held_vld", q_if.dt_vld_out, 1);
      chk("held_wrap_d", q_if.data_out, 0);
      chk("held_wrap_c", q_if.order_cnt_out, 1);
      send("wrap1", 0, 1, 1, 1, 2);
      send("wrap4", 5, 3, 4, 8, 5);

      start = 1'b1;
      x_in  = 32'd7;
      tick();
      start = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_zero("rst_prep");

      build("build3", 32'd3);
      send("x3_p", 1, 1, 1, 10, 2);
      drive(2, 2, 1, 1'b1);
      tick();
      q_if.dt_vld_i = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk("rst_run_drop", q_if.dt_vld_out, 0);
      chk("rst_run_rdy", q_if.mux2que_rdy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
